// File: rtl/icache_pkg.sv
// icache_pkg: shared widths and FSM encoding for the instruction cache
package icache_pkg;
    localparam int ICACHE_TAG_W    = 20;
    localparam int ICACHE_IDX_W    = 6;
    localparam int ICACHE_OFFSET_W = 6;
    localparam int ICACHE_LINE_W   = 512;
    typedef enum logic {ICACHE_IDLE, ICACHE_MISS} icache_state_t;
endpackage

// File: rtl/icache_data_bank.sv
// icache_data_bank: line storage with combinational read and synchronous write
module icache_data_bank
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_IDX_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [INDEX_WIDTH-1:0]   waddr,
    input  logic [ICACHE_LINE_W-1:0] wdata,
    input  logic [INDEX_WIDTH-1:0]   raddr,
    output logic [ICACHE_LINE_W-1:0] rdata
);
    logic [ICACHE_LINE_W-1:0] mem [1<<INDEX_WIDTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache with single-line refill
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_WIDTH = ICACHE_IDX_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cpu_req,
    input  logic [31:0]              cpu_addr,
    input  logic                     cpu_flush,
    output logic                     cpu_stall,
    output logic [31:0]              cpu_rdata,
    output logic                     ird_req,
    output logic [31:0]              ird_addr,
    input  logic                     i_reload,
    input  logic [ICACHE_LINE_W-1:0] icacheline_new,
    output logic [31:0]              hit_cnt,
    output logic [31:0]              miss_cnt
);
    localparam int OFFSET_WIDTH = ICACHE_OFFSET_W;
    localparam int TAG_W = 32 - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int LINES = 1 << INDEX_WIDTH;
    icache_state_t state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic flush_pend;
    logic [INDEX_WIDTH-1:0] idx, ird_idx;
    logic [ICACHE_LINE_W-1:0] line;
    logic hit, refill, unused_ok;
    assign idx       = cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign ird_idx   = ird_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign unused_ok = ^{cpu_addr[1:0], ird_addr[OFFSET_WIDTH-1:0]};
    // a flush in the lookup cycle forces a miss so stale data is never returned
    assign hit       = state == ICACHE_IDLE && valid[idx] && tags[idx] == cpu_addr[31 -: TAG_W] && !cpu_flush;
    assign cpu_stall = state == ICACHE_MISS || (cpu_req && !hit);
    assign refill    = state == ICACHE_MISS && i_reload;
    assign cpu_rdata = line[{cpu_addr[5:2], 5'b0} +: 32];
    icache_data_bank #(.INDEX_WIDTH(INDEX_WIDTH)) u_bank (
        .clk  (clk),
        .we   (refill),
        .waddr(ird_idx),
        .wdata(icacheline_new),
        .raddr(idx),
        .rdata(line)
    );
    always_ff @(posedge clk)
        if (refill) tags[ird_idx] <= ird_addr[31 -: TAG_W];
    // the pending refill index/tag live in ird_addr, which is held through MISS
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ICACHE_IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            ird_req    <= 1'b0;
            ird_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else if (state == ICACHE_IDLE) begin
            if (cpu_flush) valid <= '0;
            if (cpu_req && hit) hit_cnt <= hit_cnt + 32'd1;
            if (cpu_req && !hit) begin
                state    <= ICACHE_MISS;
                ird_req  <= 1'b1;
                ird_addr <= {cpu_addr[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                miss_cnt <= miss_cnt + 32'd1;
            end
        end else begin
            if (cpu_flush) flush_pend <= 1'b1;
            if (i_reload) begin
                state      <= ICACHE_IDLE;
                ird_req    <= 1'b0;
                ird_addr   <= '0;
                flush_pend <= 1'b0;
                if (flush_pend || cpu_flush) valid <= '0;
                else valid[ird_idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache
module tb_icache;
    logic clk = 1'b0;
    logic resetn, cpu_req, cpu_flush, cpu_stall, ird_req, i_reload;
    logic [31:0] cpu_addr, cpu_rdata, ird_addr, hit_cnt, miss_cnt;
    logic [511:0] icacheline_new;
    int n_cmp = 0;
    int n_err = 0;

    icache dut (
        .clk           (clk),
        .resetn        (resetn),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_flush     (cpu_flush),
        .cpu_stall     (cpu_stall),
        .cpu_rdata     (cpu_rdata),
        .ird_req       (ird_req),
        .ird_addr      (ird_addr),
        .i_reload      (i_reload),
        .icacheline_new(icacheline_new),
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tg, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tg, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base + k;
        return l;
    endfunction

    // T: lookup misses; T+1..R: request held; R+1: retried lookup hits
    task automatic miss_fill(input logic [31:0] a, input logic [31:0] base, input int gap, input string tg);
        cpu_req = 1'b1;
        cpu_addr = a;
        #1;
        check({tg, "_miss"}, 32'(cpu_stall), 32'd1);
        tick;
        check({tg, "_req"}, 32'(ird_req), 32'd1);
        check({tg, "_addr"}, ird_addr, {a[31:6], 6'b0});
        for (int i = 0; i < gap; i++) begin
            tick;
            check({tg, "_hold_req"}, 32'(ird_req), 32'd1);
            check({tg, "_hold_addr"}, ird_addr, {a[31:6], 6'b0});
            check({tg, "_hold_stall"}, 32'(cpu_stall), 32'd1);
        end
        i_reload = 1'b1;
        icacheline_new = mk_line(base);
        #1;
        check({tg, "_r_stall"}, 32'(cpu_stall), 32'd1);
        tick;
        i_reload = 1'b0;
        #1;
        check({tg, "_req_low"}, 32'(ird_req), 32'd0);
        check({tg, "_hit"}, 32'(cpu_stall), 32'd0);
        check({tg, "_data"}, cpu_rdata, base + 32'(a[5:2]));
    endtask

    initial begin
        resetn = 1'b0;
        cpu_req = 1'b1;
        cpu_addr = 32'hBFC0_0000;
        cpu_flush = 1'b0;
        i_reload = 1'b0;
        icacheline_new = '0;
        repeat (2) tick;
        check("rst_ird_req", 32'(ird_req), 32'd0);
        check("rst_ird_addr", ird_addr, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd1);
        resetn = 1'b1;
        miss_fill(32'hBFC0_0000, 32'h1000_0000, 2, "cold");
        tick;
        cpu_addr = 32'hBFC0_003C;
        #1;
        check("cold_w15_stall", 32'(cpu_stall), 32'd0);
        check("cold_w15_data", cpu_rdata, 32'h1000_000F);
        tick;
        miss_fill(32'h0040_0040, 32'h2000_0000, 20, "hs");
        tick;
        miss_fill(32'h0000_1000, 32'h3000_0000, 1, "cf_a");
        miss_fill(32'h0000_2000, 32'h4000_0000, 1, "cf_b");
        miss_fill(32'h0000_1000, 32'h3100_0000, 1, "cf_a2");
        miss_fill(32'h0000_0080, 32'h8000_0000, 0, "fl_a");
        miss_fill(32'h0000_00C0, 32'h9000_0000, 0, "fl_b");
        tick;
        cpu_req = 1'b0;
        cpu_flush = 1'b1;
        tick;
        cpu_flush = 1'b0;
        miss_fill(32'h0000_0080, 32'h8100_0000, 0, "fl_a2");
        miss_fill(32'h0000_00C0, 32'h9100_0000, 0, "fl_b2");
        tick;
        cpu_addr = 32'h0000_0100;
        #1;
        check("fm_req", 32'(cpu_stall), 32'd1);
        tick;
        cpu_flush = 1'b1;
        tick;
        cpu_flush = 1'b0;
        i_reload = 1'b1;
        icacheline_new = mk_line(32'h7000_0000);
        tick;
        i_reload = 1'b0;
        #1;
        check("fm_req_low", 32'(ird_req), 32'd0);
        check("fm_invalid", 32'(cpu_stall), 32'd1);
        tick;
        check("fm_rereq", 32'(ird_req), 32'd1);
        i_reload = 1'b1;
        icacheline_new = mk_line(32'h7100_0000);
        tick;
        i_reload = 1'b0;
        #1;
        check("fm_hit", 32'(cpu_stall), 32'd0);
        check("fm_data", cpu_rdata, 32'h7100_0000);
        cpu_flush = 1'b1;
        #1;
        check("fl_same_cycle", 32'(cpu_stall), 32'd1);
        tick;
        cpu_flush = 1'b0;
        i_reload = 1'b1;
        icacheline_new = mk_line(32'h6000_0000);
        tick;
        i_reload = 1'b0;
        #1;
        check("fl_same_refill", cpu_rdata, 32'h6000_0000);
        tick;
        cpu_addr = 32'h0000_0140;
        #1;
        check("rd_miss", 32'(cpu_stall), 32'd1);
        tick;
        cpu_addr = 32'h0000_0100;
        #1;
        check("rd_hold1", 32'(cpu_stall), 32'd1);
        tick;
        check("rd_hold2", 32'(cpu_stall), 32'd1);
        i_reload = 1'b1;
        icacheline_new = mk_line(32'h5000_0000);
        tick;
        i_reload = 1'b0;
        #1;
        check("rd_hit", 32'(cpu_stall), 32'd0);
        check("rd_data", cpu_rdata, 32'h6000_0000);
        cpu_addr = 32'h0000_0144;
        #1;
        check("rd_new_hit", 32'(cpu_stall), 32'd0);
        check("rd_new_data", cpu_rdata, 32'h5000_0001);
        tick;
        cpu_req = 1'b0;
        i_reload = 1'b1;
        icacheline_new = '0;
        tick;
        i_reload = 1'b0;
        cpu_req = 1'b1;
        cpu_addr = 32'h0000_0000;
        #1;
        check("idle_reload", 32'(cpu_stall), 32'd1);
        tick;
        check("rm_req", 32'(ird_req), 32'd1);
        resetn = 1'b0;
        tick;
        check("rm_req_low", 32'(ird_req), 32'd0);
        check("rm_addr", ird_addr, 32'd0);
        check("rm_cold", 32'(cpu_stall), 32'd1);
        check("rm_miss_cnt", miss_cnt, 32'd0);
        resetn = 1'b1;
        miss_fill(32'h0000_0000, 32'hA000_0000, 0, "cn_a");
        miss_fill(32'h0000_0040, 32'hB000_0000, 0, "cn_b");
        miss_fill(32'h0000_0080, 32'hC000_0000, 0, "cn_c");
        repeat (10) tick;
        cpu_req = 1'b0;
        #1;
        check("cnt_miss", miss_cnt, 32'd3);
        check("cnt_hit", hit_cnt, 32'd10);
        tick;
        check("cnt_idle", hit_cnt, 32'd10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
